// File: rtl/trigger_bank.sv
// Bank of NUM_TRIG one-shot price triggers evaluated against top-of-book quotes.
// Optional auto-rearm on accept is enabled by defining TRIGGER_REARM_EN.
module trigger_bank #(
  parameter int PRICE_W  = 8,
  parameter int NUM_TRIG = 4,
  parameter int IDX_W    = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                trigger_write_enable,
  input  logic [IDX_W-1:0]    trigger_write_index,
  input  logic                trigger_side,
  input  logic                trigger_direction,
  input  logic [PRICE_W-1:0]  trigger_price,
  input  logic                trigger_rearm,
  input  logic                trigger_cancel,
  input  logic [PRICE_W-1:0]  bid_price,
  input  logic [PRICE_W-1:0]  ask_price,
  input  logic                quote_valid,
  output logic                fire_valid,
  input  logic                fire_ready,
  output logic [IDX_W-1:0]    fire_index,
  output logic                fire_side,
  output logic [PRICE_W-1:0]  fire_price,
  output logic [NUM_TRIG-1:0] armed_mask,
  output logic                trigger_satisfied
);

  // Handshake: a fire transfers on any rising edge where fire_valid & fire_ready;
  // fire_* are stable while fire_valid & !fire_ready except when a lower slot
  // fires or the presented slot is rewritten/cancelled.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } slot_state_t;

  slot_state_t         r_state  [NUM_TRIG];
  logic [PRICE_W-1:0]  r_thresh [NUM_TRIG];
  logic [PRICE_W-1:0]  r_capt   [NUM_TRIG];
  logic [NUM_TRIG-1:0] r_side;
  logic [NUM_TRIG-1:0] r_dir;

`ifdef TRIGGER_REARM_EN
  logic [NUM_TRIG-1:0] r_rearm;
`else
  logic w_unused_rearm;
  assign w_unused_rearm = trigger_rearm;
`endif

  logic [PRICE_W-1:0]  w_sel [NUM_TRIG];
  logic [NUM_TRIG-1:0] w_cmp;
  logic [NUM_TRIG-1:0] w_wr_hit;
  logic [NUM_TRIG-1:0] w_cn_hit;
  logic                w_fire_valid;
  logic [IDX_W-1:0]    w_fire_idx;
  logic                w_fire_side;
  logic [PRICE_W-1:0]  w_fire_price;
  logic                w_accept;

  // Index decode by equality, so out-of-range indices match no slot.
  always_comb begin
    w_wr_hit = '0;
    w_cn_hit = '0;
    w_cmp    = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      w_wr_hit[i] = trigger_write_enable && (trigger_write_index == IDX_W'(i));
      w_cn_hit[i] = trigger_cancel && (trigger_write_index == IDX_W'(i));
      w_sel[i]    = r_side[i] ? ask_price : bid_price;
      w_cmp[i]    = r_dir[i] ? (w_sel[i] >= r_thresh[i]) : (w_sel[i] <= r_thresh[i]);
    end
  end

  // Lowest fired slot wins: scan downward so the last hit is the lowest index.
  always_comb begin
    w_fire_valid = 1'b0;
    w_fire_idx   = '0;
    w_fire_side  = 1'b0;
    w_fire_price = '0;
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (r_state[i] == ST_FIRED) begin
        w_fire_valid = 1'b1;
        w_fire_idx   = IDX_W'(i);
        w_fire_side  = r_side[i];
        w_fire_price = r_capt[i];
      end
    end
  end

  assign w_accept = w_fire_valid && fire_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        r_state[i]  <= ST_IDLE;
        r_thresh[i] <= '0;
        r_capt[i]   <= '0;
      end
      r_side <= '0;
      r_dir  <= '0;
`ifdef TRIGGER_REARM_EN
      r_rearm <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (w_wr_hit[i]) begin
          r_state[i]  <= ST_ARMED;
          r_side[i]   <= trigger_side;
          r_dir[i]    <= trigger_direction;
          r_thresh[i] <= trigger_price;
`ifdef TRIGGER_REARM_EN
          r_rearm[i]  <= trigger_rearm;
`endif
        end else if (w_cn_hit[i]) begin
          r_state[i] <= ST_IDLE;
        end else if (r_state[i] == ST_ARMED && quote_valid && w_cmp[i]) begin
          r_state[i] <= ST_FIRED;
          r_capt[i]  <= w_sel[i];
        end else if (r_state[i] == ST_FIRED && w_accept && w_fire_idx == IDX_W'(i)) begin
`ifdef TRIGGER_REARM_EN
          r_state[i] <= r_rearm[i] ? ST_ARMED : ST_IDLE;
`else
          r_state[i] <= ST_IDLE;
`endif
        end
      end
    end
  end

  always_comb begin
    armed_mask = '0;
    for (int i = 0; i < NUM_TRIG; i++) armed_mask[i] = (r_state[i] == ST_ARMED);
  end

  assign fire_valid        = w_fire_valid;
  assign fire_index        = w_fire_idx;
  assign fire_side         = w_fire_side;
  assign fire_price        = w_fire_price;
  assign trigger_satisfied = w_fire_valid;

endmodule

// File: tb/tb_trigger_bank.sv
// Directed bench for trigger_bank (default 8-bit prices, 4 slots).
module tb_trigger_bank;
  localparam int PRICE_W  = 8;
  localparam int NUM_TRIG = 4;
  localparam int IDX_W    = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                trigger_write_enable;
  logic [IDX_W-1:0]    trigger_write_index;
  logic                trigger_side;
  logic                trigger_direction;
  logic [PRICE_W-1:0]  trigger_price;
  logic                trigger_rearm;
  logic                trigger_cancel;
  logic [PRICE_W-1:0]  bid_price;
  logic [PRICE_W-1:0]  ask_price;
  logic                quote_valid;
  logic                fire_valid;
  logic                fire_ready;
  logic [IDX_W-1:0]    fire_index;
  logic                fire_side;
  logic [PRICE_W-1:0]  fire_price;
  logic [NUM_TRIG-1:0] armed_mask;
  logic                trigger_satisfied;

  int n_tests = 0;
  int n_fail  = 0;

  trigger_bank #(.PRICE_W(PRICE_W), .NUM_TRIG(NUM_TRIG), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset(reset),
    .trigger_write_enable(trigger_write_enable), .trigger_write_index(trigger_write_index),
    .trigger_side(trigger_side), .trigger_direction(trigger_direction),
    .trigger_price(trigger_price), .trigger_rearm(trigger_rearm),
    .trigger_cancel(trigger_cancel), .bid_price(bid_price), .ask_price(ask_price),
    .quote_valid(quote_valid), .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_index(fire_index), .fire_side(fire_side), .fire_price(fire_price),
    .armed_mask(armed_mask), .trigger_satisfied(trigger_satisfied)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic side, input logic dir,
                    input logic [PRICE_W-1:0] price, input logic rearm);
    trigger_write_enable = 1'b1;
    trigger_write_index  = IDX_W'(idx);
    trigger_side         = side;
    trigger_direction    = dir;
    trigger_price        = price;
    trigger_rearm        = rearm;
    tick();
    trigger_write_enable = 1'b0;
    trigger_rearm        = 1'b0;
  endtask

  task automatic quote(input logic [PRICE_W-1:0] bid, input logic [PRICE_W-1:0] ask);
    quote_valid = 1'b1;
    bid_price   = bid;
    ask_price   = ask;
    tick();
    quote_valid = 1'b0;
  endtask

  task automatic check_fire(input string tag, input logic [IDX_W-1:0] idx,
                            input logic side, input logic [PRICE_W-1:0] price);
    check({tag, ".valid"}, 32'(fire_valid), 32'd1);
    check({tag, ".index"}, 32'(fire_index), 32'(idx));
    check({tag, ".side"},  32'(fire_side),  32'(side));
    check({tag, ".price"}, 32'(fire_price), 32'(price));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".valid"}, 32'(fire_valid),        32'd0);
    check({tag, ".index"}, 32'(fire_index),        32'd0);
    check({tag, ".side"},  32'(fire_side),         32'd0);
    check({tag, ".price"}, 32'(fire_price),        32'd0);
    check({tag, ".armed"}, 32'(armed_mask),        32'd0);
    check({tag, ".sat"},   32'(trigger_satisfied), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    trigger_write_enable = 1'b0; trigger_write_index = '0; trigger_side = 1'b0;
    trigger_direction = 1'b0; trigger_price = '0; trigger_rearm = 1'b0;
    trigger_cancel = 1'b0; bid_price = '0; ask_price = '0; quote_valid = 1'b0;
    fire_ready = 1'b0;
    #2;
    tick(); tick();
    reset = 1'b0;
    check_idle_outputs("reset");

    // Slot 0: bid <= 0x50
    wr(0, 1'b0, 1'b0, 8'h50, 1'b0);
    check("wr0.armed", 32'(armed_mask), 32'b0001);
    quote(8'h51, 8'h00);
    check("q51.valid", 32'(fire_valid), 32'd0);
    quote(8'h50, 8'h00);
    check_fire("q50", 2'd0, 1'b0, 8'h50);
    check("q50.armed", 32'(armed_mask), 32'b0000);
    check("q50.sat", 32'(trigger_satisfied), 32'd1);
    fire_ready = 1'b1; tick(); fire_ready = 1'b0;
    check("acc0.valid", 32'(fire_valid), 32'd0);

    // Slots 1 and 3 on ask >=, both fire on one quote, drained in index order
    wr(1, 1'b1, 1'b1, 8'h20, 1'b0);
    wr(3, 1'b1, 1'b1, 8'h10, 1'b0);
    check("wr13.armed", 32'(armed_mask), 32'b1010);
    quote(8'h00, 8'h30);
    check_fire("multi", 2'd1, 1'b1, 8'h30);
    tick();
    check_fire("hold", 2'd1, 1'b1, 8'h30);
    check("multi.armed", 32'(armed_mask), 32'b0000);
    fire_ready = 1'b1;
    tick();
    check_fire("drain3", 2'd3, 1'b1, 8'h30);
    tick();
    fire_ready = 1'b0;
    check("drained.valid", 32'(fire_valid), 32'd0);

    // Slot 2 pending, then simultaneous write+cancel on it: write wins
    wr(2, 1'b0, 1'b0, 8'h40, 1'b0);
    quote(8'h40, 8'h00);
    check_fire("s2", 2'd2, 1'b0, 8'h40);
    trigger_cancel = 1'b1;
    wr(2, 1'b0, 1'b0, 8'h05, 1'b0);
    trigger_cancel = 1'b0;
    check("wrcn.valid", 32'(fire_valid), 32'd0);
    check("wrcn.armed", 32'(armed_mask), 32'b0100);
    quote(8'h06, 8'h00);
    check("q06.valid", 32'(fire_valid), 32'd0);
    quote(8'h05, 8'h00);
    check_fire("q05", 2'd2, 1'b0, 8'h05);
    fire_ready = 1'b1; tick(); fire_ready = 1'b0;
    check("acc2.armed", 32'(armed_mask), 32'b0000);

    // Write coinciding with a quote: that quote is not evaluated for the slot
    quote_valid = 1'b1; bid_price = 8'h00;
    wr(0, 1'b0, 1'b0, 8'h10, 1'b0);
    quote_valid = 1'b0;
    check("wrq.valid", 32'(fire_valid), 32'd0);
    check("wrq.armed", 32'(armed_mask), 32'b0001);
    bid_price = 8'h00; tick();
    check("qv0.valid", 32'(fire_valid), 32'd0);
    quote(8'h00, 8'h00);
    check_fire("q00", 2'd0, 1'b0, 8'h00);

    // Lower slot firing preempts a held higher slot
    wr(3, 1'b1, 1'b0, 8'h80, 1'b0);
    wr(1, 1'b1, 1'b1, 8'h90, 1'b0);
    check_fire("pre0", 2'd0, 1'b0, 8'h00);
    fire_ready = 1'b1; tick(); fire_ready = 1'b0;
    quote(8'h00, 8'h70);
    check_fire("s3", 2'd3, 1'b1, 8'h70);
    quote(8'h00, 8'h95);
    check_fire("preempt", 2'd1, 1'b1, 8'h95);

    // Reset with slots pending clears everything
    reset = 1'b1; tick(); reset = 1'b0;
    check_idle_outputs("rst2");

    // Rearm flag: refires only when the feature is built in
    wr(0, 1'b0, 1'b0, 8'h40, 1'b1);
    quote(8'h30, 8'h00);
    check_fire("rearm1", 2'd0, 1'b0, 8'h30);
    fire_ready = 1'b1; tick(); fire_ready = 1'b0;
`ifdef TRIGGER_REARM_EN
    check("rearm.armed", 32'(armed_mask), 32'b0001);
    quote(8'h35, 8'h00);
    check_fire("rearm2", 2'd0, 1'b0, 8'h35);
`else
    check("rearm.armed", 32'(armed_mask), 32'b0000);
    quote(8'h35, 8'h00);
    check("rearm2.valid", 32'(fire_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
